// File: rtl/oam_dma_pkg.sv
// Shared constants, state type and source-page mapping for the OAM DMA engine.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_LEN      = 160;
  localparam logic [7:0]  ECHO_HI      = 8'hE0;

  typedef enum logic [1:0] {StIdle, StStart, StXfer, StDone} dma_state_t;

  // Pages 0xE0-0xFF alias work RAM 0x20 pages lower (echo mirror).
  function automatic logic [7:0] map_src_hi(input logic [7:0] hi);
    return (hi >= ECHO_HI) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/dma_phase_counter.sv
// Per-byte phase counter and byte index for the OAM copy, with terminal flags.
module dma_phase_counter
  import oam_dma_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               clear_i,
  input  logic                               en_i,
  output logic [$clog2(CYCLES_PER_BYTE)-1:0] phase_o,
  output logic [7:0]                         idx_o,
  output logic                               last_phase_o,
  output logic                               last_byte_o
);

  localparam int unsigned PhW = $clog2(CYCLES_PER_BYTE);

  logic [PhW-1:0] phase_q, phase_d;
  logic [7:0]     idx_q, idx_d;

  assign last_phase_o = (phase_q == PhW'(CYCLES_PER_BYTE - 1));
  assign last_byte_o  = (idx_q == 8'(OAM_LEN - 1));
  assign phase_o      = phase_q;
  assign idx_o        = idx_q;

  // Next-state: clear wins; index advances on the last phase and never passes 159.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    if (clear_i) begin
      phase_d = '0;
      idx_d   = '0;
    end else if (en_i) begin
      if (last_phase_o) begin
        phase_d = '0;
        idx_d   = last_byte_o ? 8'd0 : idx_q + 8'd1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to 0xFF46 copies 160 bytes from page V into OAM 0xFE00-0xFE9F.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [15:0] reg_addr_i,
  input  logic [7:0]  reg_wdata_i,
  input  logic        reg_we_i,
  input  logic        reg_re_i,
  output logic [7:0]  reg_rdata_o,
  output logic [15:0] m_addr_o,
  output logic        m_rd_o,
  input  logic [7:0]  m_rdata_i,
  output logic        m_wr_o,
  output logic [7:0]  m_wdata_o,
  output logic        dma_active_o,
  output logic        dma_done_o
);

  localparam int unsigned PhW  = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DlyW = $clog2(START_DELAY + 1);

  dma_state_t     state_q, state_d;
  logic [DlyW-1:0] cnt_q, cnt_d;
  logic [7:0]     src_hi_q, hold_q;
  logic [15:0]    m_addr_q;
  logic [PhW-1:0] phase;
  logic [7:0]     idx;
  logic           last_phase, last_byte, reg_hit_wr, in_xfer;

  assign reg_hit_wr = reg_we_i && (reg_addr_i == DMA_REG_ADDR);
  assign in_xfer    = (state_q == StXfer);

  dma_phase_counter #(
    .CYCLES_PER_BYTE(CYCLES_PER_BYTE)
  ) u_phase_counter (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .clear_i     (reg_hit_wr),
    .en_i        (in_xfer),
    .phase_o     (phase),
    .idx_o       (idx),
    .last_phase_o(last_phase),
    .last_byte_o (last_byte)
  );

  // Next-state logic; a register write restarts from any state. The write cycle itself
  // is the first START_DELAY clock, so the first read lands START_DELAY clocks later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StStart: begin
        if (cnt_q == DlyW'(1)) state_d = StXfer;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      StXfer:  if (last_phase && last_byte) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (reg_hit_wr) begin
      state_d = (START_DELAY > 1) ? StStart : StXfer;
      cnt_d   = DlyW'(START_DELAY - 1);
    end
  end

  // Bus-master strobes decoded from phase; address holds between strobes.
  always_comb begin
    m_rd_o    = 1'b0;
    m_wr_o    = 1'b0;
    m_wdata_o = 8'h00;
    m_addr_o  = m_addr_q;
    if (in_xfer) begin
      if (phase == PhW'(0)) begin
        m_rd_o   = 1'b1;
        m_addr_o = {map_src_hi(src_hi_q), idx};
      end else if (phase == PhW'(2)) begin
        m_wr_o    = 1'b1;
        m_addr_o  = OAM_BASE + {8'h00, idx};
        m_wdata_o = hold_q;
      end
    end
  end

  assign dma_active_o = (state_q == StStart) || in_xfer;
  assign dma_done_o   = (state_q == StDone);
  assign reg_rdata_o  = (reg_re_i && (reg_addr_i == DMA_REG_ADDR)) ? src_hi_q : 8'h00;

  // State, source page, holding byte and address registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      src_hi_q <= 8'h00;
      hold_q   <= 8'h00;
      m_addr_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_addr_q <= m_addr_o;
      if (reg_hit_wr)                      src_hi_q <= reg_wdata_i;
      if (in_xfer && (phase == PhW'(1)))   hold_q   <= m_rdata_i;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench: a default build (4 clocks/byte, delay 4) and a fast build (3, 1).
module tb_oam_dma;

  localparam int CPB0 = 4, SD0 = 4, CPB1 = 3, SD1 = 1, LEN = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we0, reg_we1, reg_re;
  logic [7:0]  rdata[2], mwdata[2], mrdata[2];
  logic [15:0] maddr[2];
  logic        mrd[2], mwr[2], act[2], done[2];

  oam_dma #(.CYCLES_PER_BYTE(CPB0), .START_DELAY(SD0)) dut0 (
    .clk_i(clk), .reset_ni(reset_n), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
    .reg_we_i(reg_we0), .reg_re_i(reg_re), .reg_rdata_o(rdata[0]), .m_addr_o(maddr[0]),
    .m_rd_o(mrd[0]), .m_rdata_i(mrdata[0]), .m_wr_o(mwr[0]), .m_wdata_o(mwdata[0]),
    .dma_active_o(act[0]), .dma_done_o(done[0])
  );

  oam_dma #(.CYCLES_PER_BYTE(CPB1), .START_DELAY(SD1)) dut1 (
    .clk_i(clk), .reset_ni(reset_n), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
    .reg_we_i(reg_we1), .reg_re_i(reg_re), .reg_rdata_o(rdata[1]), .m_addr_o(maddr[1]),
    .m_rd_o(mrd[1]), .m_rdata_i(mrdata[1]), .m_wr_o(mwr[1]), .m_wdata_o(mwdata[1]),
    .dma_active_o(act[1]), .dma_done_o(done[1])
  );

  // Source memory: byte at {hi, lo} holds lo ^ 0x5A, returned the cycle after the read.
  always @(posedge clk) begin
    if (mrd[0]) mrdata[0] <= maddr[0][7:0] ^ 8'h5A;
    if (mrd[1]) mrdata[1] <= maddr[1][7:0] ^ 8'h5A;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      cyc;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         exp_q[2][$];
  longint      done_exp[2], aws[2], awe[2], pws[2], pwe[2], last_t;
  logic [15:0] addr_exp[2];
  int          n_done[2];
  int          n_chk = 0, n_fail = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      done_exp[d] = -1;
      aws[d] = 0; awe[d] = 0; pws[d] = 0; pwe[d] = 0;
      addr_exp[d] = 16'h0000;
    end
  endtask

  // Reference: a copy started at cycle t reads byte i at t+sd+i*cpb and writes it two
  // clocks later; done follows the full 160-byte span. A restart drops anything after t.
  task automatic issue_dma(input int d, input logic [7:0] v, input longint t);
    int cpb = (d == 0) ? CPB0 : CPB1;
    int sd  = (d == 0) ? SD0 : SD1;
    logic [7:0] hi = (v >= 8'hE0) ? v - 8'h20 : v;
    ev_t e;
    while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1].cyc > t)
      void'(exp_q[d].pop_back());
    if (done_exp[d] > t) done_exp[d] = -1;
    pws[d] = aws[d];
    pwe[d] = (awe[d] > t) ? t + 1 : awe[d];
    aws[d] = t;
    awe[d] = t + sd + LEN * cpb;
    for (int i = 0; i < LEN; i++) begin
      e.cyc = t + sd + i * cpb; e.wr = 1'b0; e.addr = {hi, 8'(i)}; e.data = 8'h00;
      exp_q[d].push_back(e);
      e.cyc = e.cyc + 2; e.wr = 1'b1; e.addr = 16'hFE00 + 16'(i); e.data = 8'(i) ^ 8'h5A;
      exp_q[d].push_back(e);
    end
    done_exp[d] = awe[d];
  endtask

  task automatic check_dut(input int d);
    ev_t e;
    bit  exp_act;
    while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
      e = exp_q[d].pop_front();
      n_chk++; n_fail++;
      $display("FAIL missed_strobe dut%0d: no strobe by cycle %0d, required wr=%0b addr=%h at %0d",
               d, cyc, e.wr, e.addr, e.cyc);
    end
    if (mrd[d] || mwr[d]) begin
      n_chk++;
      if (exp_q[d].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe dut%0d cycle %0d: rd=%0b wr=%0b addr=%h, required none",
                 d, cyc, mrd[d], mwr[d], maddr[d]);
      end else begin
        e = exp_q[d].pop_front();
        addr_exp[d] = e.addr;
        if (e.cyc != cyc || mrd[d] != !e.wr || mwr[d] != e.wr || maddr[d] != e.addr ||
            (e.wr && mwdata[d] != e.data)) begin
          n_fail++;
          $display("FAIL strobe dut%0d: got cyc=%0d rd=%0b wr=%0b addr=%h data=%h, required cyc=%0d wr=%0b addr=%h data=%h",
                   d, cyc, mrd[d], mwr[d], maddr[d], mwdata[d], e.cyc, e.wr, e.addr, e.data);
        end
      end
    end else begin
      n_chk++;
      if (maddr[d] != addr_exp[d]) begin
        n_fail++;
        $display("FAIL addr_hold dut%0d cycle %0d: got %h, required %h", d, cyc, maddr[d],
                 addr_exp[d]);
      end
    end
    if (mrd[d] && mwr[d]) begin
      n_chk++; n_fail++;
      $display("FAIL strobe_overlap dut%0d cycle %0d: rd and wr both 1, required exclusive", d, cyc);
    end
    if (done[d]) begin
      n_chk++; n_done[d]++;
      if (done_exp[d] != cyc) begin
        n_fail++;
        $display("FAIL done_pulse dut%0d: got at cycle %0d, required at %0d", d, cyc, done_exp[d]);
      end
      done_exp[d] = -1;
    end else if (done_exp[d] >= 0 && done_exp[d] <= cyc) begin
      n_chk++; n_fail++;
      $display("FAIL done_missing dut%0d: got 0 at cycle %0d, required 1", d, cyc);
      done_exp[d] = -1;
    end
    exp_act = (cyc > aws[d] && cyc < awe[d]) || (cyc > pws[d] && cyc < pwe[d]);
    n_chk++;
    if (act[d] != exp_act) begin
      n_fail++;
      $display("FAIL dma_active dut%0d cycle %0d: got %0b, required %0b", d, cyc, act[d], exp_act);
    end
  endtask

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check_dut(0);
      check_dut(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int d, input logic [15:0] a, input logic [7:0] v);
    reg_addr = a; reg_wdata = v;
    if (d == 0) reg_we0 = 1'b1;
    else        reg_we1 = 1'b1;
    last_t = cyc;
    if (a == 16'hFF46) issue_dma(d, v, cyc);
    tick();
    reg_we0 = 1'b0; reg_we1 = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] req, input string name);
    reg_addr = a; reg_re = 1'b1;
    #1;
    n_chk++;
    if (rdata[0] !== req) begin
      n_fail++;
      $display("FAIL %s: reg_rdata got %h, required %h", name, rdata[0], req);
    end
    tick();
    reg_re = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while ((exp_q[d].size() > 0 || done_exp[d] >= 0) && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout dut%0d: %0d events still pending, required 0", d, exp_q[d].size());
    end
  endtask

  task automatic wait_until(input longint target);
    while (cyc < target) tick();
  endtask

  task automatic check_all_zero(input int d, input string name);
    n_chk++;
    if ({maddr[d], mrd[d], mwr[d], mwdata[d], act[d], done[d]} !== '0) begin
      n_fail++;
      $display("FAIL %s dut%0d: addr=%h rd=%0b wr=%0b wdata=%h act=%0b done=%0b, required all 0",
               name, d, maddr[d], mrd[d], mwr[d], mwdata[d], act[d], done[d]);
    end
  endtask

  initial begin
    int base;
    logic [7:0] v;
    reset_n = 1'b0; reg_addr = 16'h0000; reg_wdata = 8'h00;
    reg_we0 = 1'b0; reg_we1 = 1'b0; reg_re = 1'b0;
    n_done[0] = 0; n_done[1] = 0; last_t = 0;
    model_reset();
    repeat (3) tick();
    check_all_zero(0, "reset_state");
    check_all_zero(1, "reset_state");
    cpu_read(16'hFF46, 8'h00, "reset_src_hi");
    reset_n = 1'b1;
    tick();

    // Fast build: 481-clock transfer, rd/capture/wr back to back.
    cpu_write(1, 16'hFF46, 8'h45);
    wait_idle(1, 700);

    // Plain copy from 0xC100 with register reads during and after.
    cpu_write(0, 16'hFF46, 8'hC1);
    repeat (100) tick();
    cpu_read(16'hFF46, 8'hC1, "read_during");
    cpu_read(16'hFF45, 8'h00, "read_other");
    wait_idle(0, 1000);
    cpu_read(16'hFF46, 8'hC1, "read_after");

    // Echo page maps 0xE3 to 0xC3.
    cpu_write(0, 16'hFF46, 8'hE3);
    wait_idle(0, 1000);

    // Restart on byte 50 phase 1: exactly one done pulse for the pair.
    base = n_done[0];
    cpu_write(0, 16'hFF46, 8'h80);
    wait_until(last_t + SD0 + 50 * CPB0 + 1);
    cpu_write(0, 16'hFF46, 8'h90);
    wait_idle(0, 1000);
    n_chk++;
    if (n_done[0] - base != 1) begin
      n_fail++;
      $display("FAIL restart_done_count: got %0d pulses, required 1", n_done[0] - base);
    end

    // Other addresses are ignored.
    cpu_write(0, 16'hFF47, 8'h12);
    repeat (20) tick();
    cpu_read(16'hFF46, 8'h90, "read_after_ignored");

    // Random pages at random gaps; short gaps restart the copy in flight.
    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom);
      cpu_write(0, 16'hFF46, v);
      repeat ($urandom_range(0, 700)) tick();
    end
    wait_idle(0, 1000);

    // Reset during byte 20 aborts immediately and stays quiet afterwards.
    cpu_write(0, 16'hFF46, 8'hC1);
    wait_until(last_t + SD0 + 20 * CPB0 + 1);
    reset_n = 1'b0;
    #1;
    check_all_zero(0, "reset_abort");
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (60) tick();
    cpu_read(16'hFF46, 8'h00, "read_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine: a CPU write to register 0xFF46 copies 160 bytes from {V,8'h00} into OAM at 0xFE00-0xFE9F.
- Sits directly upstream of the whizgraphics peripheral: bus master on the system data bus, feeding OAM writes into the video block.
- Asserts dma_active so the system arbiter blocks CPU non-HRAM access for the duration of the copy.

Parameters:
- CYCLES_PER_BYTE, 4, clocks spent per copied byte; must be >= 3.
- START_DELAY, 4, clocks between the register write and the first source read.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- reg_addr  in  16  CPU register address.
- reg_wdata  in  8  CPU write data.
- reg_we  in  1  CPU write strobe, single-cycle.
- reg_re  in  1  CPU read strobe.
- reg_rdata  out  8  read data; valid the same cycle as reg_re when reg_addr==0xFF46, else 8'h00.
- m_addr  out  16  bus-master address.
- m_rd  out  1  master read strobe.
- m_rdata  in  8  read data, valid the cycle after m_rd.
- m_wr  out  1  master write strobe.
- m_wdata  out  8  master write data.
- dma_active  out  1  transfer in progress.
- dma_done  out  1  one-cycle pulse after the last OAM write.

Behaviour:
- Reset: all outputs 0; internal src_hi = 0; state IDLE. Reset asserted mid-transfer aborts immediately; no further m_rd/m_wr.
- Register:
  - reg_we with reg_addr==0xFF46 latches reg_wdata into src_hi and enters START.
  - Reads of 0xFF46 return the last written value, whether or not a transfer is active.
- Source mapping: src_hi >= 8'hE0 maps to src_hi-8'h20 (echo RAM mirror). Effective source = {mapped_hi, idx}.
- States:
  - IDLE: waits for a register write.
  - START: counts START_DELAY clocks, dma_active=1, then goes to XFER with idx=0, phase=0.
  - XFER: phase counter 0..CYCLES_PER_BYTE-1 per byte.
    - phase 0: m_rd=1, m_addr=source+idx.
    - phase 1: capture m_rdata into a holding register.
    - phase 2: m_wr=1, m_addr=16'hFE00+idx, m_wdata=held byte.
    - remaining phases: idle.
    - At the last phase: idx increments; if idx was 159, go to DONE.
  - DONE: one cycle, dma_done=1, dma_active=0, then IDLE.
- dma_active is 1 in START and XFER only.
- Latency: first OAM write occurs START_DELAY+2 clocks after the reg_we cycle. Total transfer is START_DELAY + 160*CYCLES_PER_BYTE clocks.
- Strobes: m_rd and m_wr are never high in the same cycle. m_addr holds its value when both strobes are low.
- Restart: a register write during START or XFER reloads src_hi, resets idx=0 and phase=0, and re-enters START. No dma_done pulse for the aborted copy. A write landing exactly on a phase-2 cycle still issues that cycle's OAM write.
- Writes to other addresses are ignored. Writes to 0xFF46 in DONE behave as from IDLE.
- Width rules: idx is 8 bits, range 0-159 (no wrap past 159). Source address low byte = idx, so no carry into the high byte.

Decomposition:
- Package oam_dma_pkg:
  - DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_LEN=160, ECHO_HI=8'hE0.
  - dma_state_t enum {IDLE, START, XFER, DONE}.
- One natural sub-module: dma_phase_counter. Generates the phase and idx counters with terminal flags last_phase and last_byte; clear input used for restart.

Test Plan:
- Write 8'hC1 to 0xFF46, source memory holds idx^8'h5A -> 160 m_wr to 0xFE00..0xFE9F with data idx^8'h5A. First m_rd to 0xC100 at +START_DELAY clocks. dma_done at +4+640 clocks from reg_we. dma_active high throughout.
- Write 8'hE3 -> m_rd addresses 0xC300..0xC39F (echo mirror); OAM destinations unchanged.
- Write 8'h80, then 8'h90 on byte 50 phase 1 -> writes for bytes 0-49 from 0x80xx, then a full 160-byte copy from 0x9000. Exactly one dma_done pulse.
- Deassert reset_n during byte 20 -> all outputs 0 the same cycle. No strobes after reset release until a new 0xFF46 write.
- Read 0xFF46 during and after a transfer started with 8'hC1 -> reg_rdata=8'hC1. Read 0xFF45 -> 8'h00. No strobe overlap across the whole run (assertion: !(m_rd && m_wr)).
- CYCLES_PER_BYTE=3, START_DELAY=1 build -> transfer length 481 clocks. Back-to-back bytes show the rd/capture/wr pattern with no idle phase.
